// File: rtl/approx_add_err_monitor_if.sv
// Sample bus into the approximate-adder error monitor: operands, approximate sum and a
// valid/ready handshake.
interface approx_add_err_monitor_if #(
  parameter int unsigned W = 8
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic [W:0]   approx_sum;

  modport master (
    output in_valid,
    output in_a,
    output in_b,
    output approx_sum,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_a,
    input  in_b,
    input  approx_sum,
    output in_ready
  );
endinterface

// File: rtl/approx_add_err_monitor.sv
// Compares each accepted approximate sum against the exact a+b and accumulates error
// statistics over a run of SAMPLES accepted samples.
module approx_add_err_monitor #(
  parameter int unsigned W       = 8,
  parameter int unsigned SAMPLES = 256,
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned ACC_W   = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  approx_add_err_monitor_if.slave in_if,
  output logic                  done,
  output logic [CNT_W-1:0]      err_count,
  output logic [W:0]            max_abs_err,
  output logic [ACC_W-1:0]      sum_abs_err,
  output logic [ACC_W-1:0]      hamming_sum
);

  // Wide enough for an accumulator plus a full diff, with one carry bit to spot overflow.
  localparam int unsigned SumW = ((ACC_W > W + 1) ? ACC_W : W + 1) + 1;
  localparam logic [CNT_W-1:0] LastIdx = CNT_W'(SAMPLES - 1);
  localparam logic [SumW-1:0] AccMax = {{(SumW - ACC_W){1'b0}}, {ACC_W{1'b1}}};

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e           state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             clear;
  logic             accept;

  logic             valid1_q;
  logic [W:0]       exact1_q;
  logic [W:0]       approx1_q;

  logic [CNT_W-1:0] err_q, err_d;
  logic [W:0]       max_q, max_d;
  logic [ACC_W-1:0] sum_q, sum_d;
  logic [ACC_W-1:0] ham_q, ham_d;

  logic [W:0]       diff;
  logic [SumW-1:0]  ham;
  logic [SumW-1:0]  sum_ext;
  logic [SumW-1:0]  ham_ext;

  assign accept = in_if.in_valid & in_ready_q;

  always_comb begin
    state_d    = state_q;
    in_ready_d = in_ready_q;
    cnt_d      = cnt_q;
    clear      = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d    = StRun;
          in_ready_d = 1'b1;
          cnt_d      = '0;
          clear      = 1'b1;
        end
      end
      StRun: begin
        if (accept) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LastIdx) begin
            state_d    = StDrain;
            in_ready_d = 1'b0;
          end
        end
      end
      StDrain: begin
        // Stage 2 has nothing left to fold in once stage 1 is empty.
        if (!valid1_q) state_d = StDone;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    diff = (approx1_q >= exact1_q) ? (approx1_q - exact1_q) : (exact1_q - approx1_q);
    ham  = '0;
    for (int unsigned i = 0; i <= W; i++) begin
      ham = ham + SumW'(approx1_q[i] ^ exact1_q[i]);
    end
    sum_ext = SumW'(sum_q) + SumW'(diff);
    ham_ext = SumW'(ham_q) + ham;

    err_d = err_q;
    max_d = max_q;
    sum_d = sum_q;
    ham_d = ham_q;
    if (clear) begin
      err_d = '0;
      max_d = '0;
      sum_d = '0;
      ham_d = '0;
    end else if (valid1_q) begin
      err_d = err_q + CNT_W'(diff != '0);
      max_d = (diff > max_q) ? diff : max_q;
      sum_d = (sum_ext > AccMax) ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
      ham_d = (ham_ext > AccMax) ? {ACC_W{1'b1}} : ham_ext[ACC_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      in_ready_q <= 1'b0;
      cnt_q      <= '0;
      valid1_q   <= 1'b0;
      exact1_q   <= '0;
      approx1_q  <= '0;
      err_q      <= '0;
      max_q      <= '0;
      sum_q      <= '0;
      ham_q      <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      cnt_q      <= cnt_d;
      valid1_q   <= accept;
      if (accept) begin
        exact1_q  <= {1'b0, in_if.in_a} + {1'b0, in_if.in_b};
        approx1_q <= in_if.approx_sum;
      end
      err_q <= err_d;
      max_q <= max_d;
      sum_q <= sum_d;
      ham_q <= ham_d;
    end
  end

  assign in_if.in_ready = in_ready_q;
  assign done           = (state_q == StDone);
  assign err_count      = err_q;
  assign max_abs_err    = max_q;
  assign sum_abs_err    = sum_q;
  assign hamming_sum    = ham_q;

endmodule

// File: tb/tb_approx_add_err_monitor.sv
// Bench for approx_add_err_monitor: randomized runs checked every cycle against a
// run-level behavioural model, plus directed runs pinned to hand-computed totals.
module tb_approx_add_err_monitor;

  localparam int unsigned W       = 8;
  localparam int unsigned SAMPLES = 3;
  localparam int unsigned CNT_W   = 16;
  localparam int unsigned ACC_W   = 10;
  localparam longint     AccMax   = (64'd1 << ACC_W) - 1;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             done;
  logic [CNT_W-1:0] err_count;
  logic [W:0]       max_abs_err;
  logic [ACC_W-1:0] sum_abs_err;
  logic [ACC_W-1:0] hamming_sum;

  approx_add_err_monitor_if #(.W(W)) bus ();

  approx_add_err_monitor #(
    .W      (W),
    .SAMPLES(SAMPLES),
    .CNT_W  (CNT_W),
    .ACC_W  (ACC_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .in_if      (bus.slave),
    .done       (done),
    .err_count  (err_count),
    .max_abs_err(max_abs_err),
    .sum_abs_err(sum_abs_err),
    .hamming_sum(hamming_sum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: phase 0 idle, 1 accepting, 2 draining, 3 finished.
  bit     m_known = 1'b0;
  int     m_phase = 0;
  bit     m_ready = 1'b0;
  bit     m_done  = 1'b0;
  bit     m_zero  = 1'b0;
  int     m_nacc  = 0;
  int     m_rem   = 0;
  longint m_err, m_max, m_sum, m_ham;

  task automatic m_clear();
    m_err = 0;
    m_max = 0;
    m_sum = 0;
    m_ham = 0;
  endtask

  task automatic m_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W:0] x);
    longint     exact, diff;
    logic [W:0] e9;
    exact = longint'(a) + longint'(b);
    diff  = (longint'(x) > exact) ? longint'(x) - exact : exact - longint'(x);
    e9    = (W + 1)'(exact);
    if (diff != 0) m_err++;
    if (diff > m_max) m_max = diff;
    m_sum = (m_sum + diff > AccMax) ? AccMax : m_sum + diff;
    m_ham = m_ham + longint'($countones(x ^ e9));
    if (m_ham > AccMax) m_ham = AccMax;
  endtask

  // Compare the current cycle, then predict what the coming edge does.
  always @(negedge clk) begin
    if (m_known) begin
      chk("in_ready", 64'(bus.in_ready), 64'(m_ready));
      chk("done", 64'(done), 64'(m_done));
      if (m_done || m_zero) begin
        chk("err_count", 64'(err_count), 64'(m_err));
        chk("max_abs_err", 64'(max_abs_err), 64'(m_max));
        chk("sum_abs_err", 64'(sum_abs_err), 64'(m_sum));
        chk("hamming_sum", 64'(hamming_sum), 64'(m_ham));
      end
    end
    if (!rst_n) begin
      m_known = 1'b1;
      m_phase = 0;
      m_ready = 1'b0;
      m_done  = 1'b0;
      m_zero  = 1'b1;
      m_nacc  = 0;
      m_clear();
    end else if (m_known) begin
      case (m_phase)
        0, 3: begin
          if (start) begin
            m_phase = 1;
            m_ready = 1'b1;
            m_done  = 1'b0;
            m_zero  = 1'b0;
            m_nacc  = 0;
            m_clear();
          end
        end
        1: begin
          if (bus.in_valid && m_ready) begin
            m_add(bus.in_a, bus.in_b, bus.approx_sum);
            m_nacc++;
            if (m_nacc == int'(SAMPLES)) begin
              m_ready = 1'b0;
              m_phase = 2;
              m_rem   = 1;
            end
          end
        end
        default: begin
          if (m_rem == 0) begin
            m_phase = 3;
            m_done  = 1'b1;
          end else begin
            m_rem--;
          end
        end
      endcase
    end
  end

  logic [W-1:0] qa[$];
  logic [W-1:0] qb[$];
  logic [W:0]   qx[$];

  task automatic push(input int a, input int b, input int x);
    qa.push_back(W'(a));
    qb.push_back(W'(b));
    qx.push_back((W + 1)'(x));
  endtask

  task automatic fill_random(input int n, input bit exact_only);
    logic [W-1:0] a, b;
    logic [W:0]   e, x;
    qa.delete();
    qb.delete();
    qx.delete();
    for (int i = 0; i < n; i++) begin
      a = W'($urandom);
      b = W'($urandom);
      e = {1'b0, a} + {1'b0, b};
      case (exact_only ? 0 : $urandom_range(0, 3))
        0:       x = e;
        1:       x = e ^ ((W + 1)'(1) << $urandom_range(0, W));
        2:       x = (W + 1)'($urandom);
        default: x = e + (W + 1)'($urandom_range(1, 7));
      endcase
      qa.push_back(a);
      qb.push_back(b);
      qx.push_back(x);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // gap_mode: 0 always valid, 1 random gaps, 2 valid pattern 1,0,0,1,0,0...
  task automatic run_q(input int gap_mode, input bit start_mid);
    int idx;
    bit v, acc;
    idx   = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      case (gap_mode)
        0:       v = 1'b1;
        1:       v = ($urandom_range(0, 3) != 0);
        default: v = (cyc % 3 == 0);
      endcase
      if (idx >= qa.size()) v = 1'b0;
      bus.in_valid = v;
      if (v) begin
        bus.in_a       = qa[idx];
        bus.in_b       = qb[idx];
        bus.approx_sum = qx[idx];
      end else begin
        bus.in_a       = W'($urandom);
        bus.in_b       = W'($urandom);
        bus.approx_sum = (W + 1)'($urandom);
      end
      start = start_mid && (cyc == 1);
      @(negedge clk);
      acc = bus.in_valid && bus.in_ready;
      tick();
      if (acc) idx++;
    end
    start        = 1'b0;
    bus.in_valid = 1'b0;
    chk("run_done", 64'(done), 64'd1);
    chk("run_transfers", 64'(idx), 64'(qa.size()));
    repeat (2) tick();
  endtask

  task automatic chk_stats(input string tag, input int e, input int mx, input int s, input int h);
    chk({tag, "_err"}, 64'(err_count), 64'(e));
    chk({tag, "_max"}, 64'(max_abs_err), 64'(mx));
    chk({tag, "_sum"}, 64'(sum_abs_err), 64'(s));
    chk({tag, "_ham"}, 64'(hamming_sum), 64'(h));
  endtask

  initial begin
    rst_n          = 1'b0;
    start          = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_a       = '0;
    bus.in_b       = '0;
    bus.approx_sum = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (2) tick();
    chk_stats("reset", 0, 0, 0, 0);

    fill_random(SAMPLES, 1'b1);
    run_q(0, 1'b0);
    chk_stats("exact", 0, 0, 0, 0);

    qa.delete(); qb.delete(); qx.delete();
    push(3, 0, 0); push(5, 6, 11); push(0, 0, 0);
    run_q(0, 1'b0);
    chk_stats("single", 1, 3, 3, 2);

    qa.delete(); qb.delete(); qx.delete();
    push(255, 255, 0); push(1, 1, 2); push(0, 0, 4);
    run_q(2, 1'b0);
    chk_stats("triple", 2, 510, 514, 9);

    qa.delete(); qb.delete(); qx.delete();
    push(255, 255, 0); push(255, 255, 0); push(255, 255, 0);
    run_q(1, 1'b0);
    chk_stats("sat", 3, 510, 1023, 24);

    fill_random(SAMPLES, 1'b0);
    run_q(2, 1'b1);

    // Reset in the middle of a run, with a sample still in flight.
    fill_random(SAMPLES, 1'b0);
    start = 1'b1;
    tick();
    start          = 1'b0;
    bus.in_valid   = 1'b1;
    bus.in_a       = qa[0];
    bus.in_b       = qb[0];
    bus.approx_sum = qx[0];
    repeat (2) tick();
    bus.in_valid = 1'b0;
    rst_n        = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    chk_stats("midrst", 0, 0, 0, 0);
    chk("midrst_done", 64'(done), 64'd0);

    fill_random(SAMPLES, 1'b0);
    run_q(0, 1'b0);

    for (int r = 0; r < 30; r++) begin
      fill_random(SAMPLES, 1'b0);
      run_q($urandom_range(0, 2), ($urandom_range(0, 3) == 0));
    end

    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
